// File: rtl/dco_coarse_cal_if.sv
// Control/status bundle between the DCO coarse calibrator and its requester.
// The controller side uses the slave modport; the requester side uses master.
interface dco_coarse_cal_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] target_cnt;
  logic [3:0]       cnf_coarse;
  logic             clk_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] meas_cnt;

  modport master (
    output start, target_cnt,
    input  cnf_coarse, clk_en, busy, done, meas_cnt
  );

  modport slave (
    input  start, target_cnt,
    output cnf_coarse, clk_en, busy, done, meas_cnt
  );
endinterface

// File: rtl/dco_coarse_cal.sv
// Successive-approximation coarse-code calibration for the DCO, measuring divided DCO toggles per window.
// Define DCO_COARSE_CAL_TRACK_EN to keep re-measuring after lock and nudge the code by one step per window.
module dco_coarse_cal #(
  parameter int CNT_W      = 16,
  parameter int WIN_CYC    = 1024,
  parameter int SETTLE_CYC = 16,
  parameter int TRK_TOL    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dco_tgl,
  dco_coarse_cal_if.slave bus
);

  localparam int CYC_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int CYC_W   = (CYC_MAX > 2) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0] WIN_LAST    = CYC_W'(WIN_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEAS, DECIDE, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       coarse, coarse_nxt;
  logic [1:0]       bit_idx, bit_idx_nxt;
  logic [CYC_W-1:0] cyc, cyc_nxt;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_nxt, cnt_upd;
  logic [CNT_W-1:0] meas, meas_nxt;
  logic             tgl_s1, tgl_s2, tgl_hist, tgl_evt;
  logic             tracking, start_ok;

  // dco_tgl is asynchronous; both edges of the synchronized level count as events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgl_s1   <= 1'b0;
      tgl_s2   <= 1'b0;
      tgl_hist <= 1'b0;
    end else begin
      tgl_s1   <= dco_tgl;
      tgl_s2   <= tgl_s1;
      tgl_hist <= tgl_s2;
    end
  end

  assign tgl_evt = tgl_s2 ^ tgl_hist;

`ifdef DCO_COARSE_CAL_TRACK_EN
  logic             tracking_nxt;
  logic [CNT_W:0]   meas_w, tgt_w, tol_w;

  assign meas_w = {1'b0, meas};
  assign tgt_w  = {1'b0, bus.target_cnt};
  assign tol_w  = (CNT_W+1)'(TRK_TOL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tracking <= 1'b0;
    else        tracking <= tracking_nxt;
  end
`else
  assign tracking = 1'b0;
`endif

  // Tracking loops are reported as "done", so a new request is accepted there too
  assign start_ok = (state == IDLE) || (state == DONE) || tracking;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      coarse   <= '0;
      bit_idx  <= '0;
      cyc      <= '0;
      edge_cnt <= '0;
      meas     <= '0;
    end else begin
      state    <= state_nxt;
      coarse   <= coarse_nxt;
      bit_idx  <= bit_idx_nxt;
      cyc      <= cyc_nxt;
      edge_cnt <= edge_cnt_nxt;
      meas     <= meas_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    coarse_nxt   = coarse;
    bit_idx_nxt  = bit_idx;
    cyc_nxt      = cyc;
    edge_cnt_nxt = edge_cnt;
    meas_nxt     = meas;
    cnt_upd      = edge_cnt;
`ifdef DCO_COARSE_CAL_TRACK_EN
    tracking_nxt = tracking;
`endif
    case (state)
      SETTLE: begin
        if (cyc == SETTLE_LAST) begin
          state_nxt    = MEAS;
          cyc_nxt      = '0;
          edge_cnt_nxt = '0;
        end else begin
          cyc_nxt = cyc + CYC_W'(1);
        end
      end
      MEAS: begin
        // Saturating count; the final cycle's event is included in the loaded result
        if (tgl_evt && (edge_cnt != '1)) cnt_upd = edge_cnt + CNT_W'(1);
        edge_cnt_nxt = cnt_upd;
        if (cyc == WIN_LAST) begin
          state_nxt = DECIDE;
          cyc_nxt   = '0;
          meas_nxt  = cnt_upd;
        end else begin
          cyc_nxt = cyc + CYC_W'(1);
        end
      end
      DECIDE: begin
`ifdef DCO_COARSE_CAL_TRACK_EN
        if (tracking) begin
          if (meas_w > tgt_w + tol_w) begin
            if (coarse != 4'd0) coarse_nxt = coarse - 4'd1;
          end else if (meas_w + tol_w < tgt_w) begin
            if (coarse != 4'd15) coarse_nxt = coarse + 4'd1;
          end
          state_nxt = DONE;
        end else
`endif
        begin
          if (meas > bus.target_cnt) coarse_nxt[bit_idx] = 1'b0;
          if (bit_idx != 2'd0) begin
            bit_idx_nxt                    = bit_idx - 2'd1;
            coarse_nxt[bit_idx - 2'd1]     = 1'b1;
            state_nxt                      = SETTLE;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
`ifdef DCO_COARSE_CAL_TRACK_EN
        state_nxt    = SETTLE;
        cyc_nxt      = '0;
        tracking_nxt = 1'b1;
`endif
      end
      default: ;
    endcase

    if (start_ok && bus.start) begin
      state_nxt   = SETTLE;
      coarse_nxt  = 4'b1000;
      bit_idx_nxt = 2'd3;
      cyc_nxt     = '0;
`ifdef DCO_COARSE_CAL_TRACK_EN
      tracking_nxt = 1'b0;
`endif
    end
  end

  assign bus.cnf_coarse = coarse;
  assign bus.clk_en     = (state != IDLE);
  assign bus.busy       = ((state == SETTLE) || (state == MEAS) || (state == DECIDE)) && !tracking;
  assign bus.done       = (state == DONE) || tracking;
  assign bus.meas_cnt   = meas;

endmodule
